csr_read_arbiter: RTL and testbench
===================================

CSR_READ_ARBITER -- requirements
Module: csr_read_arbiter

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 3, meaning the maximum number of high-word mismatch retries per 64-bit read.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port req_valid_i, input, 2, per-requester request valid (bit0 pipeline, bit1 debug).
REQ-005 SHALL have port req_ready_o, output, 2, per-requester request accept.
REQ-006 SHALL have ports req0_cnt_i and req1_cnt_i, input, 1 each, counter select (0 cycle, 1 instret).
REQ-007 SHALL have ports req0_mode_i and req1_mode_i, input, 2 each, read mode (0 low word, 1 high word, 2 full 64-bit, 3 reserved, treated as 2).
REQ-008 SHALL have port CSRSel_o, output, 2, select into the CSR unit mux, encoded {cnt, hi}.
REQ-009 SHALL have port CSR_IN_i, input, 32, the CSR unit's combinational output for the current CSRSel_o.
REQ-010 SHALL have ports rsp_valid_o, rsp_id_o, rsp_err_o, rsp_data_o: output, widths 1/1/1/64, response valid, winning requester, retry exhausted, read data.
REQ-011 SHALL have port rsp_ready_i, input, 1, response accept.

Function
REQ-012 SHALL implement FSM states IDLE, RD_HI1, RD_LO, RD_HI2, RESP.
REQ-013 SHALL assert req_ready_o only in IDLE, combinationally, for exactly one requester with req_valid_i set; a request is accepted when valid and ready are both high at a clock edge.
REQ-014 SHALL arbitrate round-robin; the priority pointer starts at requester 0 and moves to the other requester on each RESP handshake.
REQ-015 SHALL latch the winner's id, cnt, and mode on accept, clear rsp_data_o and the retry count, then go to RD_LO for mode 0 and to RD_HI1 otherwise.
REQ-016 SHALL drive CSRSel_o as {cnt,1} in RD_HI1/RD_HI2, {cnt,0} in RD_LO, and 2'd0 in IDLE/RESP.
REQ-017 RD_HI1: SHALL capture CSR_IN_i into rsp_data_o[63:32], then go to RESP for mode 1 and to RD_LO for mode 2.
REQ-018 RD_LO: SHALL capture CSR_IN_i into rsp_data_o[31:0], then go to RESP for mode 0 and to RD_HI2 for mode 2.
REQ-019 RD_HI2: if CSR_IN_i equals rsp_data_o[63:32], SHALL go to RESP.
REQ-020 RD_HI2, on mismatch with retry count below MAX_RETRY: SHALL load CSR_IN_i into rsp_data_o[63:32], increment the retry count, and go to RD_LO.
REQ-021 RD_HI2, on mismatch with retry count equal to MAX_RETRY: SHALL load CSR_IN_i into [63:32], set rsp_err_o, and go to RESP.
REQ-022 Words not read by the selected mode SHALL be zero in rsp_data_o.
REQ-023 RESP: SHALL hold rsp_valid_o and all rsp_* outputs stable until rsp_ready_i is high, then go to IDLE; no new accept occurs in the same cycle.
REQ-024 Latency from accept edge T: rsp_valid_o high at T+2 for modes 0/1, and at T+4+2·retries for mode 2.
REQ-025 Request inputs SHALL be ignored outside IDLE; simultaneous valids are resolved only by the pointer.

Reset
REQ-026 On rst_ni low, SHALL asynchronously force state IDLE, pointer 0, retry count 0, rsp_valid_o 0, rsp_err_o 0, rsp_id_o 0, rsp_data_o 0, CSRSel_o 0.
REQ-027 Reset mid-transaction SHALL drop the transaction with no response; the requester reissues after reset.
REQ-028 req_ready_o SHALL be 0 while rst_ni is low.

Verification
REQ-029 Low read: req0 cnt=0 mode=0, CSR_IN_i=32'h0000_1234 -> CSRSel_o=0 at T+1; rsp at T+2 with data 64'h0000_0000_0000_1234, id 0, err 0.
REQ-030 Stable 64-bit read: req1 cnt=1 mode=2, hi=32'h5, lo=32'hA -> CSRSel_o sequence 3,2,3; rsp at T+4 with data 64'h0000_0005_0000_000A, id 1.
REQ-031 Rollover: mode=2 with hi 32'h0 at HI1, lo 32'hFFFF_FFFF, hi 32'h1 at HI2, then lo 32'h2, hi 32'h1 -> one retry; data 64'h0000_0001_0000_0002, err 0, rsp at T+6.
REQ-032 Retry exhaustion: high word changes at every RD_HI2 -> exactly MAX_RETRY retries, then rsp_err_o=1 at T+4+2·MAX_RETRY.
REQ-033 Fairness and backpressure: both valids held continuously, rsp_ready_i low for 3 cycles per response -> grants alternate 0,1,0,1 and rsp_* stay stable while stalled.
REQ-034 Reset in RD_LO: rst_ni low -> rsp_valid_o=0, CSRSel_o=0 immediately; the first grant after reset goes to requester 0.

Source files
------------

// File: rtl/csr_read_arbiter_if.sv
// csr_read_arbiter_if
// Bundles every signal between the CSR read arbiter and the two requesters,
// the CSR unit and the response consumer. The arbiter is the slave. The
// requesters and the CSR unit together form the master side.
//
//   req_valid_i  [1:0]  per-requester request valid (bit0 pipeline, bit1 debug)
//   req_ready_o  [1:0]  per-requester request accept
//   req0_cnt_i          requester 0 counter select (0 cycle, 1 instret)
//   req1_cnt_i          requester 1 counter select
//   req0_mode_i  [1:0]  requester 0 read mode (0 low, 1 high, 2/3 full 64-bit)
//   req1_mode_i  [1:0]  requester 1 read mode
//   CSRSel_o     [1:0]  CSR unit mux select, {cnt, hi}
//   CSR_IN_i     [31:0] CSR unit output for the current CSRSel_o
//   rsp_valid_o         response valid
//   rsp_id_o            requester that won the grant
//   rsp_err_o           high-word retries exhausted
//   rsp_data_o   [63:0] read data
//   rsp_ready_i         response accept
interface csr_read_arbiter_if;
   logic [1:0]  req_valid_i;
   logic [1:0]  req_ready_o;
   logic        req0_cnt_i;
   logic        req1_cnt_i;
   logic [1:0]  req0_mode_i;
   logic [1:0]  req1_mode_i;
   logic [1:0]  CSRSel_o;
   logic [31:0] CSR_IN_i;
   logic        rsp_valid_o;
   logic        rsp_id_o;
   logic        rsp_err_o;
   logic [63:0] rsp_data_o;
   logic        rsp_ready_i;

   modport slave (
      input  req_valid_i, req0_cnt_i, req1_cnt_i, req0_mode_i, req1_mode_i,
      input  CSR_IN_i, rsp_ready_i,
      output req_ready_o, CSRSel_o, rsp_valid_o, rsp_id_o, rsp_err_o, rsp_data_o
   );

   modport master (
      output req_valid_i, req0_cnt_i, req1_cnt_i, req0_mode_i, req1_mode_i,
      output CSR_IN_i, rsp_ready_i,
      input  req_ready_o, CSRSel_o, rsp_valid_o, rsp_id_o, rsp_err_o, rsp_data_o
   );
endinterface

// File: rtl/csr_read_arbiter.sv
// csr_read_arbiter
// Shares one 32-bit CSR read port between two requesters that want cycle
// or instret counter words. Full 64-bit reads use the classic hi/lo/hi
// sequence. If the high word changed while the low word was read, the low
// word is read again, up to MAX_RETRY times. After that the last high word
// is returned with rsp_err_o set.
//
//   clk_i   clock, all state changes on the rising edge
//   rst_ni  asynchronous active-low reset
//   bus     csr_read_arbiter_if.slave (request, CSR mux and response signals)
module csr_read_arbiter #(
   parameter int MAX_RETRY = 3
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   csr_read_arbiter_if.slave   bus
);

   localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   typedef enum logic [2:0] {
      IDLE,
      RD_HI1,
      RD_LO,
      RD_HI2,
      RESP
   } state_t;

   state_t        state;
   logic          ptr;
   logic [RW-1:0] retry_cnt;
   logic          cur_cnt;
   logic [1:0]    cur_mode;
   logic [1:0]    csr_sel;
   logic          rsp_valid;
   logic          rsp_id;
   logic          rsp_err;
   logic [63:0]   rsp_data;

   logic [1:0]    grant;
   logic          grant_id;
   logic          grant_cnt;
   logic [1:0]    grant_mode_raw;
   logic [1:0]    grant_mode;

   // Round-robin grant. Only IDLE can grant, and only while out of reset.
   // The pointer's requester wins if it is asking. Otherwise the other
   // requester wins.
   always_comb begin
      grant = 2'b00;
      if (rst_ni && (state == IDLE)) begin
         if (bus.req_valid_i[ptr]) begin
            grant[ptr] = 1'b1;
         end else if (bus.req_valid_i[~ptr]) begin
            grant[~ptr] = 1'b1;
         end
      end
   end

   // Pick the winner's request fields. The reserved mode 3 becomes a full
   // 64-bit read here, so the FSM only sees modes 0, 1 and 2.
   always_comb begin
      grant_id       = grant[1];
      grant_cnt      = grant_id ? bus.req1_cnt_i  : bus.req0_cnt_i;
      grant_mode_raw = grant_id ? bus.req1_mode_i : bus.req0_mode_i;
      grant_mode     = (grant_mode_raw == 2'd3) ? 2'd2 : grant_mode_raw;
   end

   // Main sequencer. CSRSel_o and the rsp_* outputs are registered. Each
   // transition loads the select for the state being entered, so the CSR
   // unit's combinational answer is ready for the capture at the next edge.
   // The response fields stay unchanged through RESP until the consumer
   // takes them.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state     <= IDLE;
         ptr       <= 1'b0;
         retry_cnt <= '0;
         cur_cnt   <= 1'b0;
         cur_mode  <= 2'd0;
         csr_sel   <= 2'd0;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_data  <= 64'd0;
      end else begin
         case (state)
            IDLE: begin
               if (|grant) begin
                  rsp_id    <= grant_id;
                  cur_cnt   <= grant_cnt;
                  cur_mode  <= grant_mode;
                  rsp_data  <= 64'd0;
                  rsp_err   <= 1'b0;
                  retry_cnt <= '0;
                  if (grant_mode == 2'd0) begin
                     state   <= RD_LO;
                     csr_sel <= {grant_cnt, 1'b0};
                  end else begin
                     state   <= RD_HI1;
                     csr_sel <= {grant_cnt, 1'b1};
                  end
               end
            end
            RD_HI1: begin
               rsp_data[63:32] <= bus.CSR_IN_i;
               if (cur_mode == 2'd1) begin
                  state     <= RESP;
                  csr_sel   <= 2'd0;
                  rsp_valid <= 1'b1;
               end else begin
                  state   <= RD_LO;
                  csr_sel <= {cur_cnt, 1'b0};
               end
            end
            RD_LO: begin
               rsp_data[31:0] <= bus.CSR_IN_i;
               if (cur_mode == 2'd0) begin
                  state     <= RESP;
                  csr_sel   <= 2'd0;
                  rsp_valid <= 1'b1;
               end else begin
                  state   <= RD_HI2;
                  csr_sel <= {cur_cnt, 1'b1};
               end
            end
            RD_HI2: begin
               // A matching high word means the low word read in between
               // belongs to the same 64-bit value. A changed high word means
               // the low word rolled over, so keep the new high word and read
               // the low word again.
               if (bus.CSR_IN_i == rsp_data[63:32]) begin
                  state     <= RESP;
                  csr_sel   <= 2'd0;
                  rsp_valid <= 1'b1;
               end else if (retry_cnt < RW'(MAX_RETRY)) begin
                  rsp_data[63:32] <= bus.CSR_IN_i;
                  retry_cnt       <= retry_cnt + 1'b1;
                  state           <= RD_LO;
                  csr_sel         <= {cur_cnt, 1'b0};
               end else begin
                  rsp_data[63:32] <= bus.CSR_IN_i;
                  rsp_err         <= 1'b1;
                  state           <= RESP;
                  csr_sel         <= 2'd0;
                  rsp_valid       <= 1'b1;
               end
            end
            RESP: begin
               if (bus.rsp_ready_i) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
                  ptr       <= ~ptr;
               end
            end
            default: begin
               state     <= IDLE;
               csr_sel   <= 2'd0;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_ready_o = grant;
   assign bus.CSRSel_o    = csr_sel;
   assign bus.rsp_valid_o = rsp_valid;
   assign bus.rsp_id_o    = rsp_id;
   assign bus.rsp_err_o   = rsp_err;
   assign bus.rsp_data_o  = rsp_data;

endmodule

// File: tb/tb_csr_read_arbiter.sv
// tb_csr_read_arbiter
// Directed bench for csr_read_arbiter. Each directed step pushes the
// response it should produce onto a scoreboard queue. When the DUT raises
// rsp_valid_o, the bench pops that entry and compares id, data, error flag,
// latency and the CSRSel_o sequence seen during the read.
// A scripted CSR unit returns script[idx] and steps idx once per read cycle.
module tb_csr_read_arbiter;

   localparam int MAX_RETRY = 3;

   typedef struct {
      logic        id;
      logic [63:0] data;
      logic        err;
      int          lat;
      logic [31:0] sels;
      int          nsel;
   } exp_t;

   logic        clk_i = 1'b0;
   logic        rst_ni;

   logic [31:0] script [16];
   int          idx = 0;
   int          cyc = 0;
   int          accept_cyc = 0;
   logic        busy = 1'b0;
   logic [1:0]  sel_log [$];
   exp_t        sb [$];
   exp_t        cur;
   int          checks = 0;
   int          passes = 0;
   int          fails = 0;

   csr_read_arbiter_if bus ();

   csr_read_arbiter #(.MAX_RETRY(MAX_RETRY)) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   // Free-running clock.
   always #5 clk_i = ~clk_i;

   // Scripted CSR unit. It returns the next word of the script for the read
   // in progress.
   assign bus.CSR_IN_i = (idx < 16) ? script[idx] : 32'd0;

   // Follows the DUT's transaction boundaries. It records the accept edge
   // for latency checks and steps the script once for each cycle the DUT
   // spends reading. It also logs the select the DUT presented in that cycle.
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy <= 1'b0;
      end else begin
         cyc <= cyc + 1;
         if (|(bus.req_valid_i & bus.req_ready_o)) begin
            accept_cyc <= cyc + 1;
            idx        <= 0;
            busy       <= 1'b1;
            sel_log.delete();
         end else if (busy && !bus.rsp_valid_o) begin
            idx <= idx + 1;
            sel_log.push_back(bus.CSRSel_o);
         end else if (bus.rsp_valid_o && bus.rsp_ready_i) begin
            busy <= 1'b0;
         end
      end
   end

   // Stops a run that hangs, reporting it as a failure first.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs,
                              input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pushExp(input logic id, input logic [63:0] data,
                          input logic err, input int lat,
                          input logic [31:0] sels, input int nsel);
      exp_t e;
      e.id   = id;
      e.data = data;
      e.err  = err;
      e.lat  = lat;
      e.sels = sels;
      e.nsel = nsel;
      sb.push_back(e);
   endtask

   // Presents a one-shot request for one cycle. The DUT is idle, so the
   // request is accepted at the edge in between.
   task automatic applyStimulus(input logic [1:0] valid,
                                input logic c0, input logic [1:0] m0,
                                input logic c1, input logic [1:0] m1);
      bus.req_valid_i = valid;
      bus.req0_cnt_i  = c0;
      bus.req0_mode_i = m0;
      bus.req1_cnt_i  = c1;
      bus.req1_mode_i = m1;
      @(negedge clk_i);
      bus.req_valid_i = 2'b00;
   endtask

   task automatic waitResponse();
      logic got;
      int   lat;
      got = 1'b0;
      for (int n = 0; n < 100 && !got; n++) begin
         if (bus.rsp_valid_o) got = 1'b1;
         else @(negedge clk_i);
      end
      checkOutput("rsp_timeout", got, 1'b1);
      checkOutput("sb_nonempty", sb.size() != 0, 1'b1);
      if (got && sb.size() != 0) begin
         cur = sb.pop_front();
         lat = cyc - accept_cyc + 1;
         checkOutput("rsp_id", bus.rsp_id_o, cur.id);
         checkOutput("rsp_data", bus.rsp_data_o, cur.data);
         checkOutput("rsp_err", bus.rsp_err_o, cur.err);
         checkOutput("latency", lat, cur.lat);
         checkOutput("sel_count", sel_log.size(), cur.nsel);
         for (int i = 0; i < cur.nsel && i < sel_log.size(); i++)
            checkOutput($sformatf("sel%0d", i), sel_log[i], cur.sels[2*i +: 2]);
      end
   endtask

   // Holds the response for 'stall' cycles and checks that nothing moves.
   // It then accepts the response and checks that valid drops.
   task automatic releaseResponse(input int stall);
      for (int s = 0; s < stall; s++) begin
         @(negedge clk_i);
         checkOutput("stall_valid", bus.rsp_valid_o, 1'b1);
         checkOutput("stall_id", bus.rsp_id_o, cur.id);
         checkOutput("stall_data", bus.rsp_data_o, cur.data);
         checkOutput("stall_err", bus.rsp_err_o, cur.err);
      end
      bus.rsp_ready_i = 1'b1;
      @(negedge clk_i);
      bus.rsp_ready_i = 1'b0;
      checkOutput("valid_drop", bus.rsp_valid_o, 1'b0);
   endtask

   // Directed sequence: reset, then low, stable 64-bit, rollover and
   // retry-exhaustion reads, then reset mid-read, then fairness under
   // backpressure.
   initial begin
      logic [31:0] sels;
      for (int i = 0; i < 16; i++) script[i] = 32'd0;
      bus.req_valid_i = 2'b00;
      bus.req0_cnt_i  = 1'b0;
      bus.req1_cnt_i  = 1'b0;
      bus.req0_mode_i = 2'd0;
      bus.req1_mode_i = 2'd0;
      bus.rsp_ready_i = 1'b0;
      rst_ni = 1'b1;
      #2 rst_ni = 1'b0;
      bus.req_valid_i = 2'b11;
      repeat (2) @(negedge clk_i);
      checkOutput("reset_valid", bus.rsp_valid_o, 1'b0);
      checkOutput("reset_sel", bus.CSRSel_o, 2'd0);
      checkOutput("reset_data", bus.rsp_data_o, 64'd0);
      checkOutput("reset_id", bus.rsp_id_o, 1'b0);
      checkOutput("reset_err", bus.rsp_err_o, 1'b0);
      checkOutput("reset_ready", bus.req_ready_o, 2'b00);
      bus.req_valid_i = 2'b00;
      rst_ni = 1'b1;
      @(negedge clk_i);

      $display("[TB] low word read");
      script[0] = 32'h0000_1234;
      pushExp(1'b0, 64'h0000_0000_0000_1234, 1'b0, 2, 32'd0, 1);
      applyStimulus(2'b01, 1'b0, 2'd0, 1'b0, 2'd0);
      waitResponse();
      releaseResponse(0);

      $display("[TB] stable 64-bit read");
      script[0] = 32'h5; script[1] = 32'hA; script[2] = 32'h5;
      pushExp(1'b1, 64'h0000_0005_0000_000A, 1'b0, 4, {26'd0, 2'd3, 2'd2, 2'd3}, 3);
      applyStimulus(2'b10, 1'b0, 2'd0, 1'b1, 2'd2);
      waitResponse();
      releaseResponse(2);

      $display("[TB] rollover read with one retry");
      script[0] = 32'h0; script[1] = 32'hFFFF_FFFF; script[2] = 32'h1;
      script[3] = 32'h2; script[4] = 32'h1;
      pushExp(1'b0, 64'h0000_0001_0000_0002, 1'b0, 6,
              {22'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1}, 5);
      applyStimulus(2'b01, 1'b0, 2'd2, 1'b0, 2'd0);
      waitResponse();
      releaseResponse(0);

      // The high word changes at every RD_HI2: hi words 10,11,.. and lo
      // words A0,A1,.. alternate. The last hi word is 0x14 and the last lo
      // word is 0xA3. Mode 3 must behave as a full read.
      $display("[TB] retry exhaustion");
      for (int r = 0; r <= MAX_RETRY + 1; r++) script[2*r] = 32'h10 + r;
      for (int r = 0; r <= MAX_RETRY; r++) script[2*r+1] = 32'hA0 + r;
      sels = 32'd0;
      for (int i = 0; i < 2*MAX_RETRY + 3; i++) sels[2*i +: 2] = (i % 2 == 0) ? 2'd1 : 2'd0;
      pushExp(1'b1, 64'h0000_0014_0000_00A3, 1'b1, 4 + 2*MAX_RETRY, sels, 2*MAX_RETRY + 3);
      applyStimulus(2'b10, 1'b0, 2'd0, 1'b0, 2'd3);
      waitResponse();
      releaseResponse(1);

      $display("[TB] reset during RD_LO");
      script[0] = 32'h77; script[1] = 32'h88;
      applyStimulus(2'b01, 1'b1, 2'd2, 1'b0, 2'd0);
      checkOutput("drop_sel_hi1", bus.CSRSel_o, 2'd3);
      @(negedge clk_i);
      checkOutput("drop_sel_lo", bus.CSRSel_o, 2'd2);
      rst_ni = 1'b0;
      bus.req_valid_i = 2'b11;
      bus.req0_cnt_i  = 1'b0;
      bus.req0_mode_i = 2'd0;
      bus.req1_cnt_i  = 1'b1;
      bus.req1_mode_i = 2'd1;
      #1;
      checkOutput("drop_valid", bus.rsp_valid_o, 1'b0);
      checkOutput("drop_sel", bus.CSRSel_o, 2'd0);
      checkOutput("drop_data", bus.rsp_data_o, 64'd0);
      checkOutput("drop_ready", bus.req_ready_o, 2'b00);
      @(negedge clk_i);
      checkOutput("drop_ready_held", bus.req_ready_o, 2'b00);

      // Both requesters keep asking. The first grant after reset goes to
      // requester 0, and later grants alternate. Each response is stalled
      // three cycles. Requester 0 reads cycle low and requester 1 reads
      // instret high.
      $display("[TB] fairness with backpressure");
      script[0] = 32'h100;
      for (int k = 0; k < 4; k++) begin
         if (k % 2 == 0)
            pushExp(1'b0, {32'd0, 32'h100 + k}, 1'b0, 2, 32'd0, 1);
         else
            pushExp(1'b1, {32'h100 + k, 32'd0}, 1'b0, 2, 32'd3, 1);
      end
      rst_ni = 1'b1;
      for (int k = 0; k < 4; k++) begin
         waitResponse();
         script[0] = 32'h100 + k + 1;
         if (k == 3) bus.req_valid_i = 2'b00;
         releaseResponse(3);
      end
      bus.req_valid_i = 2'b00;
      repeat (3) @(negedge clk_i);
      checkOutput("idle_valid", bus.rsp_valid_o, 1'b0);
      checkOutput("sb_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
